// File: rtl/axis_pkt_buffer_pkg.sv
// rtl/axis_pkt_buffer_pkg.sv - shared types and width helpers for the packet buffer
package axis_pkt_pkg;

    typedef enum logic [0:0] {
        WRITE = 1'b0,
        DROP  = 1'b1
    } wr_state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    function automatic int unsigned strb_w(input int unsigned data_width);
        return data_width / 8;
    endfunction

    // Each stored word is {tlast, tstrb, tdata}.
    function automatic int unsigned word_w(input int unsigned data_width);
        return data_width + (data_width / 8) + 1;
    endfunction

    // Pointer distance a - b, wrapped to a pointer of pw bits.
    function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b,
                                             input int unsigned pw);
        logic [31:0] mask;
        mask = (pw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << pw) - 32'd1);
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/axis_pkt_buffer_if.sv
// rtl/axis_pkt_buffer_if.sv - stream handshake bundle with master/slave views
interface axis_pkt_buffer_if
    import axis_pkt_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic [DATA_WIDTH-1:0]         tdata;
    logic [strb_w(DATA_WIDTH)-1:0] tstrb;
    logic                          tvalid;
    logic                          tlast;
    logic                          tready;

    modport master (output tdata, tstrb, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tvalid, tlast, output tready);

endinterface

// File: rtl/axis_pkt_buffer_rd_pipe.sv
// rtl/axis_pkt_buffer_rd_pipe.sv - RAM read stage tracking, output register and skid entry
module axis_pkt_rd_pipe
    import axis_pkt_pkg::*;
#(
    parameter int unsigned WORD_W = 37
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    output logic              rd_ready,
    input  logic [WORD_W-1:0] s1_word,
    output logic [WORD_W-1:0] m_word,
    output logic              m_valid,
    input  logic              m_ready
);

    logic              s1_valid;
    logic              out_valid;
    logic              skid_valid;
    logic [WORD_W-1:0] out_word;
    logic [WORD_W-1:0] skid_word;
    logic              out_take;
    logic              s1_adv;

    // Stage 1 only waits on the skid slot, so m_ready never reaches the RAM enable.
    assign out_take = out_valid & m_ready;
    assign s1_adv   = s1_valid & ~skid_valid;
    assign rd_ready = ~s1_valid | s1_adv;

    assign m_word  = out_word;
    assign m_valid = out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_word   <= '0;
            skid_word  <= '0;
        end else begin
            if (rd_en) begin
                s1_valid <= 1'b1;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            if (skid_valid) begin
                if (out_take) begin
                    out_word   <= skid_word;
                    skid_valid <= 1'b0;
                end
            end else if (s1_adv) begin
                if (!out_valid || out_take) begin
                    out_word  <= s1_word;
                    out_valid <= 1'b1;
                end else begin
                    skid_word  <= s1_word;
                    skid_valid <= 1'b1;
                end
            end else if (out_take) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axis_pkt_buffer.sv
// rtl/axis_pkt_buffer.sv - store-and-forward stream packet buffer with oversize frame drop
module axis_pkt_buffer
    import axis_pkt_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 axis_aclk,
    input  logic                 axis_aresetn,
    axis_pkt_buffer_if.slave     s_axis,
    axis_pkt_buffer_if.master    m_axis,
    output logic [CNT_WIDTH-1:0] frame_count,
    output logic [CNT_WIDTH-1:0] drop_count,
    output logic                 full,
    output logic                 empty
);

    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned PTR_W  = clog2(DEPTH) + 1;
    localparam int unsigned STRB_W = strb_w(DATA_WIDTH);
    localparam int unsigned WORD_W = word_w(DATA_WIDTH);

    localparam logic [PTR_W-1:0]     PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    if (CNT_WIDTH <= ADDR_WIDTH) begin : g_bad_cnt_width
        $error("axis_pkt_buffer: CNT_WIDTH must be greater than ADDR_WIDTH");
    end
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
        $error("axis_pkt_buffer: DATA_WIDTH must be a multiple of 8");
    end

    wr_state_t         state;
    wr_state_t         state_nxt;
    logic [PTR_W-1:0]  wr_cur;
    logic [PTR_W-1:0]  wr_cur_nxt;
    logic [PTR_W-1:0]  wr_commit;
    logic [PTR_W-1:0]  wr_commit_nxt;
    logic [PTR_W-1:0]  rd_ptr;
    logic              full_i;
    logic              oversize;
    logic              s_tready_i;
    logic              s_hs;
    logic              wr_en;
    logic              commit;
    logic              drop;
    logic              rd_en;
    logic              rd_ready;
    logic              frame_done;
    logic [WORD_W-1:0] ram [DEPTH];
    logic [WORD_W-1:0] ram_q;
    logic [WORD_W-1:0] out_word;
    logic              out_valid;

    assign full_i   = ptr_diff(32'(wr_cur), 32'(rd_ptr), PTR_W) == 32'(DEPTH);
    assign oversize = ptr_diff(32'(wr_cur), 32'(wr_commit), PTR_W) == 32'(DEPTH);

    // An oversize frame must keep flowing so it can be discarded, even when full.
    assign s_tready_i    = axis_aresetn & ((state == DROP) | ~full_i | oversize);
    assign s_axis.tready = s_tready_i;
    assign s_hs          = s_axis.tvalid & s_tready_i;

    assign full  = full_i;
    assign empty = (rd_ptr == wr_commit);

    always_comb begin
        state_nxt     = state;
        wr_cur_nxt    = wr_cur;
        wr_commit_nxt = wr_commit;
        wr_en         = 1'b0;
        commit        = 1'b0;
        drop          = 1'b0;
        if (s_hs) begin
            unique case (state)
                WRITE: begin
                    if (!oversize) begin
                        wr_en      = 1'b1;
                        wr_cur_nxt = wr_cur + PTR_ONE;
                        if (s_axis.tlast) begin
                            wr_commit_nxt = wr_cur + PTR_ONE;
                            commit        = 1'b1;
                        end
                    end else if (s_axis.tlast) begin
                        wr_cur_nxt = wr_commit;
                        drop       = 1'b1;
                    end else begin
                        state_nxt = DROP;
                    end
                end
                DROP: begin
                    if (s_axis.tlast) begin
                        wr_cur_nxt = wr_commit;
                        drop       = 1'b1;
                        state_nxt  = WRITE;
                    end
                end
                default: state_nxt = WRITE;
            endcase
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state     <= WRITE;
            wr_cur    <= '0;
            wr_commit <= '0;
        end else begin
            state     <= state_nxt;
            wr_cur    <= wr_cur_nxt;
            wr_commit <= wr_commit_nxt;
        end
    end

    // Reads only ever target committed words, so read-first collision behaviour is safe.
    assign rd_en = (rd_ptr != wr_commit) & rd_ready;

    always_ff @(posedge axis_aclk) begin
        if (wr_en) begin
            ram[wr_cur[ADDR_WIDTH-1:0]] <= {s_axis.tlast, s_axis.tstrb, s_axis.tdata};
        end
        if (rd_en) begin
            ram_q <= ram[rd_ptr[ADDR_WIDTH-1:0]];
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            rd_ptr <= '0;
        end else if (rd_en) begin
            rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    axis_pkt_rd_pipe #(
        .WORD_W (WORD_W)
    ) u_rd_pipe (
        .clk      (axis_aclk),
        .rst_n    (axis_aresetn),
        .rd_en    (rd_en),
        .rd_ready (rd_ready),
        .s1_word  (ram_q),
        .m_word   (out_word),
        .m_valid  (out_valid),
        .m_ready  (m_axis.tready)
    );

    assign m_axis.tdata  = out_word[DATA_WIDTH-1:0];
    assign m_axis.tstrb  = out_word[DATA_WIDTH +: STRB_W];
    assign m_axis.tlast  = out_word[WORD_W-1];
    assign m_axis.tvalid = out_valid;

    assign frame_done = out_valid & m_axis.tready & out_word[WORD_W-1];

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            if (commit && !frame_done) begin
                frame_count <= frame_count + CNT_ONE;
            end else if (!commit && frame_done) begin
                frame_count <= frame_count - CNT_ONE;
            end
            if (drop && (drop_count != {CNT_WIDTH{1'b1}})) begin
                drop_count <= drop_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_axis_pkt_buffer.sv
// tb/tb_axis_pkt_buffer.sv - directed self-checking bench for axis_pkt_buffer
module tb_axis_pkt_buffer;
    import axis_pkt_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 4;
    localparam int unsigned CW    = 16;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned WW    = 37;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] frame_count;
    logic [CW-1:0] drop_count;
    logic          full;
    logic          empty;

    always #5 clk = ~clk;

    axis_pkt_buffer_if #(.DATA_WIDTH(DW)) s_if ();
    axis_pkt_buffer_if #(.DATA_WIDTH(DW)) m_if ();

    axis_pkt_buffer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW)
    ) dut (
        .axis_aclk    (clk),
        .axis_aresetn (rst_n),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .frame_count  (frame_count),
        .drop_count   (drop_count),
        .full         (full),
        .empty        (empty)
    );

    int            checks = 0;
    int            errors = 0;
    logic [WW-1:0] send_q[$];
    logic [WW-1:0] exp_q[$];
    logic [WW-1:0] m_word;
    logic [WW-1:0] stall_word;
    bit            stall_prev = 0;
    int            iter = 0;
    int            tlast_iter = -10;
    int            first_valid_iter = -1;
    int            m_first_hs = -1;
    int            m_last_hs = -1;
    int            m_beats = 0;
    int            s_beats = 0;
    int            total_beats = 0;
    logic [CW-1:0] fc_probe = '0;
    logic          full_probe = 1'b0;
    logic [3:0]    strb_ctr = 4'h0;

    assign m_word = {m_if.tlast, m_if.tstrb, m_if.tdata};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a frame of at most DEPTH beats comes out unchanged, longer frames vanish.
    task automatic push_frame(input int len, input logic [31:0] base);
        logic [WW-1:0] w;
        for (int i = 0; i < len; i++) begin
            w = {(i == len - 1), strb_ctr, base + 32'(i)};
            strb_ctr = strb_ctr + 4'h1;
            send_q.push_back(w);
            if (len <= int'(DEPTH)) exp_q.push_back(w);
        end
    endtask

    task automatic run(input int max_iter, input int min_iter, input int rmode,
                       input bit wait_drain, input bit check_done, input string tag);
        int n;
        bit done;
        n = 0;
        done = 0;
        while (n < max_iter && !(done && n >= min_iter)) begin
            s_if.tvalid = (send_q.size() > 0);
            if (send_q.size() > 0) {s_if.tlast, s_if.tstrb, s_if.tdata} = send_q[0];
            m_if.tready = (rmode == 1) ? 1'b1 : (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            if (stall_prev) check("stall_hold", 64'({m_if.tvalid, m_word}), 64'({1'b1, stall_word}));
            if (m_if.tvalid && m_if.tready) begin
                check("beat_expected", 64'(exp_q.size() > 0), 64'(1'b1));
                if (exp_q.size() > 0) begin
                    check("beat_data", 64'(m_word), 64'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
                m_beats++;
                if (m_first_hs < 0) m_first_hs = iter;
                m_last_hs = iter;
            end
            stall_prev = m_if.tvalid && !m_if.tready;
            stall_word = m_word;
            if (first_valid_iter < 0 && m_if.tvalid) first_valid_iter = iter;
            if (iter == tlast_iter + 1) begin
                fc_probe   = frame_count;
                full_probe = full;
            end
            if (s_if.tvalid && s_if.tready) begin
                if (send_q[0][WW-1]) tlast_iter = iter;
                void'(send_q.pop_front());
                s_beats++;
            end
            @(negedge clk);
            iter++;
            n++;
            done = (send_q.size() == 0) && (!wait_drain || exp_q.size() == 0);
        end
        if (check_done) check({tag, "_complete"}, 64'(done), 64'(1'b1));
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b0;
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tstrb  = '0;
        s_if.tdata  = '0;
        m_if.tready = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_s_tready", 64'(s_if.tready), 64'(1'b0));
        check("rst_m_tvalid", 64'(m_if.tvalid), 64'(1'b0));
        check("rst_m_word", 64'(m_word), 64'({WW{1'b0}}));
        check("rst_full", 64'(full), 64'(1'b0));
        check("rst_empty", 64'(empty), 64'(1'b1));
        check("rst_frame_count", 64'(frame_count), 64'(16'd0));
        check("rst_drop_count", 64'(drop_count), 64'(16'd0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 3-beat frame, latency from tlast to first valid beat
        push_frame(3, 32'hA1);
        run(40, 0, 1, 1, 1, "t1");
        check("t1_latency", 64'(first_valid_iter - tlast_iter), 64'(3));
        check("t1_fc_after_commit", 64'(fc_probe), 64'(16'd1));
        check("t1_fc_end", 64'(frame_count), 64'(16'd0));
        check("t1_empty", 64'(empty), 64'(1'b1));
        check("t1_beats", 64'(m_beats), 64'(3));

        // exactly DEPTH beats: stored, then streamed without bubbles
        s_beats = 0; m_beats = 0; m_first_hs = -1;
        push_frame(16, 32'hB0);
        run(60, 20, 0, 0, 1, "t2_fill");
        check("t2_accepted", 64'(s_beats), 64'(16));
        check("t2_full", 64'(full_probe), 64'(1'b1));
        check("t2_frame_count", 64'(frame_count), 64'(16'd1));
        check("t2_nothing_out", 64'(m_beats), 64'(0));
        run(60, 0, 1, 1, 1, "t2_drain");
        check("t2_no_bubble", 64'(m_last_hs - m_first_hs), 64'(15));
        check("t2_beats", 64'(m_beats), 64'(16));
        check("t2_fc_end", 64'(frame_count), 64'(16'd0));
        check("t2_empty", 64'(empty), 64'(1'b1));

        // DEPTH+1 and DEPTH+2 beats are dropped, next frame still good
        s_beats = 0; m_beats = 0;
        push_frame(17, 32'hC0);
        run(60, 25, 1, 1, 1, "t3_drop17");
        check("t3_accepted17", 64'(s_beats), 64'(17));
        check("t3_drop1", 64'(drop_count), 64'(16'd1));
        check("t3_fc", 64'(frame_count), 64'(16'd0));
        check("t3_no_output", 64'(m_beats), 64'(0));
        push_frame(18, 32'hC8);
        run(60, 26, 1, 1, 1, "t3_drop18");
        check("t3_accepted18", 64'(s_beats), 64'(35));
        check("t3_drop2", 64'(drop_count), 64'(16'd2));
        push_frame(2, 32'hD0);
        run(40, 0, 1, 1, 1, "t3_after");
        check("t3_after_beats", 64'(m_beats), 64'(2));
        check("t3_after_empty", 64'(empty), 64'(1'b1));

        // committed frames cause backpressure; three words already sit in the read pipeline
        s_beats = 0; m_beats = 0;
        push_frame(8, 32'hE0);
        push_frame(8, 32'hE8);
        run(60, 0, 0, 0, 1, "t4_fill");
        check("t4_accepted", 64'(s_beats), 64'(16));
        check("t4_fc", 64'(frame_count), 64'(16'd2));
        push_frame(8, 32'hF0);
        run(12, 12, 0, 0, 0, "t4_block");
        check("t4_partial_accept", 64'(s_beats), 64'(19));
        check("t4_s_tready", 64'(s_if.tready), 64'(1'b0));
        check("t4_full", 64'(full), 64'(1'b1));
        check("t4_no_drop", 64'(drop_count), 64'(16'd2));
        run(100, 0, 1, 1, 1, "t4_drain");
        check("t4_beats", 64'(m_beats), 64'(24));
        check("t4_fc_end", 64'(frame_count), 64'(16'd0));
        check("t4_no_drop_end", 64'(drop_count), 64'(16'd2));

        // random downstream stalls, strobes cycle through every value
        m_beats = 0; total_beats = 0;
        for (int f = 0; f < 20; f++) begin
            int len;
            len = int'($urandom_range(1, 6));
            total_beats += len;
            push_frame(len, $urandom);
        end
        run(3000, 0, 2, 1, 1, "t5_random");
        check("t5_beats", 64'(m_beats), 64'(total_beats));
        check("t5_fc_end", 64'(frame_count), 64'(16'd0));
        check("t5_empty", 64'(empty), 64'(1'b1));

        // reset mid-frame while an output beat is stalled
        push_frame(4, 32'h60);
        run(40, 10, 0, 0, 1, "t6_fill");
        check("t6_tvalid_before", 64'(m_if.tvalid), 64'(1'b1));
        for (int i = 0; i < 2; i++) send_q.push_back({1'b0, 4'h5, 32'h6600 + 32'(i)});
        run(10, 0, 0, 0, 1, "t6_partial");
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_tvalid", 64'(m_if.tvalid), 64'(1'b0));
        check("t6_rst_m_word", 64'(m_word), 64'({WW{1'b0}}));
        check("t6_rst_fc", 64'(frame_count), 64'(16'd0));
        check("t6_rst_drop", 64'(drop_count), 64'(16'd0));
        check("t6_rst_empty", 64'(empty), 64'(1'b1));
        check("t6_rst_s_tready", 64'(s_if.tready), 64'(1'b0));
        send_q.delete();
        exp_q.delete();
        stall_prev = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m_beats = 0;
        push_frame(3, 32'h70);
        run(40, 0, 1, 1, 1, "t6_after");
        check("t6_after_beats", 64'(m_beats), 64'(3));
        check("t6_after_fc", 64'(frame_count), 64'(16'd0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
